// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the instruction-fetch stage.
// Produces the fetch address and the instruction-memory enable. It advances by
// STEP and accepts redirects from later stages. While held (stall or memory not
// ready) it stores the most recent redirect and applies it at the next advance.
//
// Ports:
//   clk             system clock, rising edge
//   rst             asynchronous reset, active high
//   stall           pipeline stall, holds pc
//   memReady        instruction memory accepted the current fetch
//   branchEnable    redirect request (one-cycle pulse)
//   branchTarget    redirect address
//   pc              current fetch address (registered)
//   chipEnable      instruction-memory enable (registered)
//   redirectPending a held redirect is waiting to be applied (registered)
module pc_gen #(
  parameter int unsigned            ADDR_WIDTH   = 32,
  parameter int unsigned            STEP         = 4,
  parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  memReady,
  input  logic                  branchEnable,
  input  logic [ADDR_WIDTH-1:0] branchTarget,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  chipEnable,
  output logic                  redirectPending
);

  // Clears the low log2(STEP) bits; an all-ones mask when STEP is 1.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STEP - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP_INC   = ADDR_WIDTH'(STEP);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_d;
  logic                    ce_d;
  logic                    pend_d;
  logic [ADDR_WIDTH-1:0]   pend_tgt_q, pend_tgt_d;
  logic [ADDR_WIDTH-1:0]   branch_aligned;
  logic                    advance;

  assign branch_aligned = branchTarget & ALIGN_MASK;
  assign advance        = !stall && memReady;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      pc              <= RESET_VECTOR;
      chipEnable      <= 1'b0;
      redirectPending <= 1'b0;
      pend_tgt_q      <= '0;
    end else begin
      state_q         <= state_d;
      pc              <= pc_d;
      chipEnable      <= ce_d;
      redirectPending <= pend_d;
      pend_tgt_q      <= pend_tgt_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc;
    ce_d       = chipEnable;
    pend_d     = redirectPending;
    pend_tgt_d = pend_tgt_q;

    unique case (state_q)
      // First edge out of reset only enables memory; RESET_VECTOR is fetched first.
      IDLE: begin
        state_d = RUN;
        ce_d    = 1'b1;
      end

      RUN: begin
        ce_d = 1'b1;
        if (advance) begin
          if (branchEnable) begin
            // A direct branch supersedes any stored redirect.
            pc_d   = branch_aligned;
            pend_d = 1'b0;
          end else if (redirectPending) begin
            pc_d   = pend_tgt_q;
            pend_d = 1'b0;
          end else begin
            pc_d = pc + STEP_INC;
          end
        end else if (branchEnable) begin
          // Held: keep the most recent redirect for the next advance.
          pend_tgt_d = branch_aligned;
          pend_d     = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed testbench for pc_gen: a 32-bit instance (STEP 4, reset vector 0x100)
// and an 8-bit instance (STEP 4, reset vector 0) for the wrap-around case.
module tb_pc_gen;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        rst, stall, mem_ready, br_en;
  logic [31:0] br_tgt;
  logic [31:0] pc;
  logic        ce, pend;

  // 8-bit instance
  logic        rst_b, stall_b, mem_ready_b, br_en_b;
  logic [7:0]  br_tgt_b;
  logic [7:0]  pc_b;
  logic        ce_b, pend_b;

  int checks = 0;
  int errors = 0;

  pc_gen #(
    .ADDR_WIDTH  (32),
    .STEP        (4),
    .RESET_VECTOR(32'h100)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .memReady       (mem_ready),
    .branchEnable   (br_en),
    .branchTarget   (br_tgt),
    .pc             (pc),
    .chipEnable     (ce),
    .redirectPending(pend)
  );

  pc_gen #(
    .ADDR_WIDTH  (8),
    .STEP        (4),
    .RESET_VECTOR(8'h00)
  ) u_dut_b (
    .clk            (clk),
    .rst            (rst_b),
    .stall          (stall_b),
    .memReady       (mem_ready_b),
    .branchEnable   (br_en_b),
    .branchTarget   (br_tgt_b),
    .pc             (pc_b),
    .chipEnable     (ce_b),
    .redirectPending(pend_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; mem_ready = 1'b1; br_en = 1'b0; br_tgt = '0;
    rst_b = 1'b1; stall_b = 1'b0; mem_ready_b = 1'b1; br_en_b = 1'b0; br_tgt_b = '0;

    // Reset and boot
    step(); step();
    check("rst_ce",   32'(ce),   32'd0);
    check("rst_pc",   pc,        32'h100);
    check("rst_pend", 32'(pend), 32'd0);
    rst = 1'b0;
    step();
    check("boot_ce",  32'(ce),   32'd1);
    check("boot_pc0", pc,        32'h100);
    step(); check("boot_pc1", pc, 32'h104);
    step(); check("boot_pc2", pc, 32'h108);
    step(); check("boot_pc3", pc, 32'h10C);

    // Re-boot; a branch presented in IDLE must be ignored
    rst = 1'b1;
    step();
    rst = 1'b0; br_en = 1'b1; br_tgt = 32'h3000;
    step();
    check("idle_br_pc", pc, 32'h100);
    br_en = 1'b0;
    step(); check("reboot_pc1", pc, 32'h104);
    step(); check("reboot_pc2", pc, 32'h108);

    // Direct branch with unaligned target
    br_en = 1'b1; br_tgt = 32'h2003;
    step();
    check("dbr_pc", pc, 32'h2000);
    br_en = 1'b0;
    step();
    check("dbr_next", pc, 32'h2004);

    // Held redirect: latest of two redirects wins
    stall = 1'b1; br_en = 1'b1; br_tgt = 32'h400;
    step();
    check("hold1_pc",   pc,        32'h2004);
    check("hold1_pend", 32'(pend), 32'd1);
    br_tgt = 32'h500;
    step();
    check("hold2_pc",   pc,        32'h2004);
    check("hold2_pend", 32'(pend), 32'd1);
    br_en = 1'b0;
    step();
    check("hold3_pc",   pc,        32'h2004);
    check("hold3_pend", 32'(pend), 32'd1);
    stall = 1'b0;
    step();
    check("rel_pc",   pc,        32'h500);
    check("rel_pend", 32'(pend), 32'd0);
    step();
    check("rel_next", pc, 32'h504);

    // Direct branch supersedes a stored redirect (hold via memReady and stall)
    stall = 1'b1; mem_ready = 1'b0; br_en = 1'b1; br_tgt = 32'h600;
    step();
    check("sup_hold_pc",   pc,        32'h504);
    check("sup_hold_pend", 32'(pend), 32'd1);
    stall = 1'b0; mem_ready = 1'b1; br_tgt = 32'h700;
    step();
    check("sup_pc",   pc,        32'h700);
    check("sup_pend", 32'(pend), 32'd0);

    // Memory wait at 0x20
    br_tgt = 32'h20;
    step();
    check("mw_pc0", pc, 32'h20);
    br_en = 1'b0; mem_ready = 1'b0;
    step();
    check("mw_pc1", pc,      32'h20);
    check("mw_ce1", 32'(ce), 32'd1);
    step();
    check("mw_pc2", pc,      32'h20);
    check("mw_ce2", 32'(ce), 32'd1);
    mem_ready = 1'b1;
    step();
    check("mw_pc3", pc, 32'h24);

    // Asynchronous reset between edges with a redirect pending
    stall = 1'b1; br_en = 1'b1; br_tgt = 32'h800;
    step();
    check("ar_pend_set", 32'(pend), 32'd1);
    br_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("ar_pc",   pc,        32'h100);
    check("ar_ce",   32'(ce),   32'd0);
    check("ar_pend", 32'(pend), 32'd0);
    stall = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("ar_boot_pc", pc, 32'h100);
    step();
    check("ar_no_redirect", pc, 32'h104);

    // Wrap-around on the 8-bit instance
    rst_b = 1'b0;
    step();
    check("wrap_boot_pc", 32'(pc_b), 32'h00);
    check("wrap_boot_ce", 32'(ce_b), 32'd1);
    br_en_b = 1'b1; br_tgt_b = 8'hFF;
    step();
    check("wrap_br_pc", 32'(pc_b), 32'hFC);
    br_en_b = 1'b0;
    step();
    check("wrap_pc", 32'(pc_b), 32'h00);
    step();
    check("wrap_next", 32'(pc_b), 32'h04);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
